ps2_scancode_rx: RTL and testbench
==================================

Name: ps2_scancode_rx

Overview:
- PS/2 device-to-host receiver: samples raw PS2_CLK/PS2_DAT, deserializes 11-bit frames and decodes E0/F0 prefixes.
- Presents held make-code `scancode` plus strobes to the game-logic key-matching block.
- Sits between the board PS/2 pins and the key-checking logic, in the CLOCK_50 domain.

Parameters:
- CLK_FILTER_LEN, 8: consecutive identical synced PS2_CLK samples required to change the filtered clock.
- TIMEOUT_CYCLES, 50000: CLOCK_50 cycles (1 ms) without a filtered falling edge before a partial frame is aborted.
- EMPTY_CODE, 8'h05: value of `scancode` when no key is held.

Ports:
- CLOCK_50  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- PS2_CLK  in  1  raw PS/2 clock pin, asynchronous.
- PS2_DAT  in  1  raw PS/2 data pin, asynchronous.
- scancode  out  8  make code of last pressed key; EMPTY_CODE after that key's break.
- code_valid  out  1  1-cycle pulse: complete (prefix-resolved) code decoded.
- is_break  out  1  qualifies code_valid; code was preceded by F0.
- is_extended  out  1  qualifies code_valid; code was preceded by E0.
- byte_out  out  8  last raw accepted byte, including E0/F0.
- byte_valid  out  1  1-cycle pulse per accepted byte.
- frame_err  out  1  1-cycle pulse per rejected or aborted frame.

Behaviour:
- Reset: all outputs 0 except `scancode` = EMPTY_CODE. FSM goes to IDLE; prefix flags clear; filtered clock = 1. Reset mid-frame discards partial data.
- Input path:
  - Two-flop synchronizer on each pin.
  - Filtered clock toggles only after CLK_FILTER_LEN equal synced samples.
  - Sample event = filtered 1->0 transition; synced PS2_DAT is captured in that cycle.
- FSM states IDLE, DATA, PARITY, STOP; bit counter 3 bits.
  - IDLE: event with DAT=0 -> DATA, counter=0. Event with DAT=1 -> stay (stray edge ignored).
  - DATA: shift DAT in LSB-first; after the 8th bit -> PARITY.
  - PARITY: store bit -> STOP.
  - STOP: on event -> IDLE. Byte is accepted iff DAT=1 and the ones-count of data+parity is odd. Otherwise frame_err pulses.
- Timeout: in any state except IDLE, idle counter >= TIMEOUT_CYCLES -> IDLE, frame_err pulse, partial byte dropped. Counter clears on every event; an event in the same cycle as expiry wins, with no error.
- Acceptance latency: byte_out/byte_valid update in the cycle after the STOP event.
- Decode in the same cycle as byte_valid:
  - E0: set ext_pending; no code_valid.
  - F0: set brk_pending; no code_valid.
  - Any other byte: code_valid=1, is_break=brk_pending, is_extended=ext_pending, both pending flags cleared.
  - Make: scancode <= byte.
  - Break with byte == scancode: scancode <= EMPTY_CODE. Break of any other key: scancode unchanged.
- is_break/is_extended hold until the next code_valid. A frame error does not clear pending flags.
- Back-to-back frames are handled with no dead cycles; scancode never glitches between codes.

Optional Feature:
- PS2_PARITY_CHECK_EN defined: a parity mismatch rejects the byte (frame_err pulse, no byte_valid, no decode).
- Undefined: the parity bit is stored but ignored; acceptance requires only stop=1. frame_err fires only on a bad stop bit or timeout.

Decomposition:
- Shared package ps2_pkg:
  - FSM state enum.
  - Constants PS2_EXT=8'hE0, PS2_BREAK=8'hF0, PS2_EMPTY=8'h05.
  - Game key codes A=8'h1C, S=8'h1B, D=8'h23, F=8'h2B, SPACE=8'h29.
- One sub-module, ps2_line_filter: synchronizers, clock filter and falling-edge detect. Outputs `fall_evt` and `dat_sync`.

Test Plan:
- Frame 0x1C (bits 0,0,0,1,1,1,0,0,0,0,1) at 12.5 kHz -> byte_valid, byte_out=1C, code_valid, scancode=1C, is_break=0, is_extended=0.
- Frames F0 then 1C after 1C is held -> byte_valid twice, one code_valid with is_break=1, scancode=05. A lone F0 yields no code_valid.
- E0 then 75 -> code_valid, is_extended=1, scancode=75. Then E0,F0,75 -> scancode=05, is_break=1, is_extended=1.
- 0x1C with parity bit 1:
  - With PS2_PARITY_CHECK_EN: frame_err pulse, no byte_valid, scancode unchanged.
  - Without the macro: byte accepted.
- 4 data bits then silence for TIMEOUT_CYCLES -> frame_err pulse, FSM in IDLE. Next clean 0x29 frame -> scancode=29.
- PS2_CLK low glitch of CLK_FILTER_LEN-2 cycles mid-frame -> no extra bit sampled, frame decodes correctly. Reset asserted after bit 5 -> all outputs at reset values, next frame decodes cleanly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scancode receiver: FSM states, protocol
// prefix bytes, the "no key held" code and the game key codes.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EMPTY = 8'h05;

    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_S     = 8'h1B;
    localparam logic [7:0] KEY_D     = 8'h23;
    localparam logic [7:0] KEY_F     = 8'h2B;
    localparam logic [7:0] KEY_SPACE = 8'h29;

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 pin conditioning: two-flop synchronizers on both pins, a run-length
// filter on the clock pin, and a one-cycle pulse on each filtered falling edge.
module ps2_line_filter #(
    parameter int CLK_FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic fall_evt,
    output logic dat_sync
);

    localparam int CNT_W = $clog2(CLK_FILTER_LEN + 1);

    logic             clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic             filt_q, filt_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive synced samples that disagree with the filtered level;
    // the filtered level flips only once CLK_FILTER_LEN of them are in a row.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        fall_d = 1'b0;
        if (clk_s2_q != filt_q) begin
            if (cnt_q == CNT_W'(CLK_FILTER_LEN - 1)) begin
                filt_d = clk_s2_q;
                fall_d = ~clk_s2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Synchronizers idle high like the bus; filter state restarts at idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
            filt_q   <= 1'b1;
            cnt_q    <= '0;
            fall_q   <= 1'b0;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_dat;
            dat_s2_q <= dat_s1_q;
            filt_q   <= filt_d;
            cnt_q    <= cnt_d;
            fall_q   <= fall_d;
        end
    end

    assign fall_evt = fall_q;
    assign dat_sync = dat_s2_q;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: frames 11-bit words on filtered clock falling
// edges, accepts bytes, and resolves E0/F0 prefixes into held make codes.
// Optional: define PS2_PARITY_CHECK_EN to reject bytes with bad odd parity.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int         CLK_FILTER_LEN = 8,
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter logic [7:0] EMPTY_CODE     = PS2_EMPTY
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] scancode,
    output logic       code_valid,
    output logic       is_break,
    output logic       is_extended,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic fall_evt, dat_sync, par_ok;

    ps2_state_e       state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
    logic [7:0]       scancode_q, scancode_d, byte_out_q, byte_out_d;
    logic             code_valid_q, code_valid_d, byte_valid_q, byte_valid_d;
    logic             is_break_q, is_break_d, is_ext_q, is_ext_d;
    logic             frame_err_q, frame_err_d;

    ps2_line_filter #(
        .CLK_FILTER_LEN(CLK_FILTER_LEN)
    ) u_line_filter (
        .clk      (CLOCK_50),
        .reset    (reset),
        .ps2_clk  (PS2_CLK),
        .ps2_dat  (PS2_DAT),
        .fall_evt (fall_evt),
        .dat_sync (dat_sync)
    );

`ifdef PS2_PARITY_CHECK_EN
    assign par_ok = ^{shift_q, par_q};
`else
    assign par_ok = 1'b1;
`endif

    // Frame FSM, inactivity timeout, byte acceptance and prefix decode.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        ext_pend_d   = ext_pend_q;
        brk_pend_d   = brk_pend_q;
        scancode_d   = scancode_q;
        byte_out_d   = byte_out_q;
        is_break_d   = is_break_q;
        is_ext_d     = is_ext_q;
        code_valid_d = 1'b0;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        if (state_q == ST_IDLE || fall_evt) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                // A high start bit is a stray edge and is ignored.
                if (fall_evt && !dat_sync) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (fall_evt) begin
                    shift_d   = {dat_sync, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (fall_evt) begin
                    par_d   = dat_sync;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall_evt) begin
                    state_d = ST_IDLE;
                    if (dat_sync && par_ok) begin
                        byte_valid_d = 1'b1;
                        byte_out_d   = shift_q;
                        if (shift_q == PS2_EXT) begin
                            ext_pend_d = 1'b1;
                        end else if (shift_q == PS2_BREAK) begin
                            brk_pend_d = 1'b1;
                        end else begin
                            code_valid_d = 1'b1;
                            is_break_d   = brk_pend_q;
                            is_ext_d     = ext_pend_q;
                            ext_pend_d   = 1'b0;
                            brk_pend_d   = 1'b0;
                            if (!brk_pend_q) begin
                                scancode_d = shift_q;
                            end else if (shift_q == scancode_q) begin
                                scancode_d = EMPTY_CODE;
                            end
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // An edge arriving on the expiry cycle keeps the frame alive.
        if (state_q != ST_IDLE && !fall_evt && tmo_q >= TMO_W'(TIMEOUT_CYCLES)) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
            tmo_d       = '0;
        end
    end

    // Control and output registers.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            tmo_q        <= '0;
            ext_pend_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
            scancode_q   <= EMPTY_CODE;
            byte_out_q   <= 8'h00;
            code_valid_q <= 1'b0;
            byte_valid_q <= 1'b0;
            is_break_q   <= 1'b0;
            is_ext_q     <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            tmo_q        <= tmo_d;
            ext_pend_q   <= ext_pend_d;
            brk_pend_q   <= brk_pend_d;
            scancode_q   <= scancode_d;
            byte_out_q   <= byte_out_d;
            code_valid_q <= code_valid_d;
            byte_valid_q <= byte_valid_d;
            is_break_q   <= is_break_d;
            is_ext_q     <= is_ext_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Frame shift register and parity bit carry no reset.
    always_ff @(posedge CLOCK_50) begin
        shift_q <= shift_d;
        par_q   <= par_d;
    end

    assign scancode    = scancode_q;
    assign code_valid  = code_valid_q;
    assign is_break    = is_break_q;
    assign is_extended = is_ext_q;
    assign byte_out    = byte_out_q;
    assign byte_valid  = byte_valid_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Scoreboard bench for ps2_scancode_rx with scaled-down PS/2 bit timing.
module tb_ps2_scancode_rx;
    import ps2_pkg::*;

    localparam int FILT = 8;
    localparam int TMO  = 1000;
    localparam int H    = 40;

    typedef struct packed {
        logic       bv;
        logic [7:0] b;
        logic       cv;
        logic       brk;
        logic       ext;
        logic [7:0] sc;
        logic       fe;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] scancode, byte_out;
    logic       code_valid, is_break, is_extended, byte_valid, frame_err;

    ev_t exp_q[$];
    ev_t obs_q[$];
    ev_t got, exp;
    int  n_cmp = 0;
    int  n_err = 0;

    logic [7:0] m_sc = PS2_EMPTY;
    logic [7:0] m_byte = 8'h00;
    logic       m_brk = 1'b0, m_ext = 1'b0, m_pb = 1'b0, m_pe = 1'b0;

    ps2_scancode_rx #(
        .CLK_FILTER_LEN(FILT),
        .TIMEOUT_CYCLES(TMO),
        .EMPTY_CODE(PS2_EMPTY)
    ) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .PS2_CLK     (ps2_clk),
        .PS2_DAT     (ps2_dat),
        .scancode    (scancode),
        .code_valid  (code_valid),
        .is_break    (is_break),
        .is_extended (is_extended),
        .byte_out    (byte_out),
        .byte_valid  (byte_valid),
        .frame_err   (frame_err)
    );

    always #10 clk = ~clk;

    // Collect every cycle that carries a strobe.
    always @(negedge clk) begin
        if (!reset && (byte_valid || code_valid || frame_err))
            obs_q.push_back({byte_valid, byte_out, code_valid, is_break, is_extended, scancode, frame_err});
    end

    function automatic string fmt(input ev_t e);
        return $sformatf("bv=%b byte=%h cv=%b brk=%b ext=%b sc=%h fe=%b",
                         e.bv, e.b, e.cv, e.brk, e.ext, e.sc, e.fe);
    endfunction

    task automatic model_reset();
        m_sc = PS2_EMPTY; m_byte = 8'h00;
        m_brk = 1'b0; m_ext = 1'b0; m_pb = 1'b0; m_pe = 1'b0;
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic exp_byte(input logic [7:0] d);
        logic cv;
        cv = 1'b0;
        m_byte = d;
        if (d == 8'hE0) m_pe = 1'b1;
        else if (d == 8'hF0) m_pb = 1'b1;
        else begin
            cv = 1'b1;
            m_brk = m_pb;
            m_ext = m_pe;
            if (!m_pb) m_sc = d;
            else if (d == m_sc) m_sc = 8'h05;
            m_pb = 1'b0; m_pe = 1'b0;
        end
        exp_q.push_back({1'b1, d, cv, m_brk, m_ext, m_sc, 1'b0});
    endtask

    task automatic exp_err();
        exp_q.push_back({1'b0, m_byte, 1'b0, m_brk, m_ext, m_sc, 1'b1});
    endtask

    // Device-side frame: data changes mid-high, clock low for H cycles per bit.
    task automatic send_frame(input logic [7:0] d, input bit flip_par, input bit bad_stop,
                              input int nbits, input int glitch_bit);
        logic [10:0] f;
        f = {~bad_stop, (~^d) ^ flip_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = f[i];
            repeat (H / 2) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (H) @(negedge clk);
            ps2_clk = 1'b1;
            if (i == glitch_bit) begin
                repeat (8) @(negedge clk);
                ps2_clk = 1'b0;
                repeat (FILT - 2) @(negedge clk);
                ps2_clk = 1'b1;
                repeat (H / 2 - 8 - (FILT - 2)) @(negedge clk);
            end else begin
                repeat (H / 2) @(negedge clk);
            end
        end
        ps2_dat = 1'b1;
    endtask

    // Bounded wait for the DUT to produce as many events as expected.
    task automatic settle();
        int n;
        n = 0;
        while (obs_q.size() < exp_q.size() && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat (30) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(negedge clk);
        got = {byte_valid, byte_out, code_valid, is_break, is_extended, scancode, frame_err};
        exp = {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h05, 1'b0};
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL reset_hold: got %s, expected %s", fmt(got), fmt(exp));
        end
        reset = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        got = {byte_valid, byte_out, code_valid, is_break, is_extended, scancode, frame_err};
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL reset_release: got %s, expected %s", fmt(got), fmt(exp));
        end
    endtask

    task automatic test_make();
        exp_byte(KEY_A); send_frame(KEY_A, 0, 0, 11, -1);
        settle();
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL make_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL make_evt: got %s, expected %s", fmt(got), fmt(exp));
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_break();
        exp_byte(PS2_BREAK); send_frame(PS2_BREAK, 0, 0, 11, -1);
        exp_byte(KEY_A);     send_frame(KEY_A, 0, 0, 11, -1);
        exp_byte(PS2_BREAK); send_frame(PS2_BREAK, 0, 0, 11, -1);
        settle();
        exp_byte(KEY_S);     send_frame(KEY_S, 0, 0, 11, -1);
        settle();
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL break_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL break_evt: got %s, expected %s", fmt(got), fmt(exp));
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_extended();
        exp_byte(PS2_EXT);   send_frame(PS2_EXT, 0, 0, 11, -1);
        exp_byte(8'h75);     send_frame(8'h75, 0, 0, 11, -1);
        exp_byte(PS2_EXT);   send_frame(PS2_EXT, 0, 0, 11, -1);
        exp_byte(PS2_BREAK); send_frame(PS2_BREAK, 0, 0, 11, -1);
        exp_byte(8'h75);     send_frame(8'h75, 0, 0, 11, -1);
        settle();
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL ext_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL ext_evt: got %s, expected %s", fmt(got), fmt(exp));
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_parity_stop();
`ifdef PS2_PARITY_CHECK_EN
        exp_err();
`else
        exp_byte(KEY_A);
`endif
        send_frame(KEY_A, 1, 0, 11, -1);
        exp_err(); send_frame(KEY_S, 0, 1, 11, -1);
        settle();
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL parity_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL parity_evt: got %s, expected %s", fmt(got), fmt(exp));
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_timeout();
        exp_err(); send_frame(8'h5A, 0, 0, 5, -1);
        repeat (TMO + 100) @(negedge clk);
        exp_byte(KEY_SPACE); send_frame(KEY_SPACE, 0, 0, 11, -1);
        settle();
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL timeout_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL timeout_evt: got %s, expected %s", fmt(got), fmt(exp));
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_glitch_reset();
        exp_byte(KEY_F); send_frame(KEY_F, 0, 0, 11, 3);
        settle();
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL glitch_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL glitch_evt: got %s, expected %s", fmt(got), fmt(exp));
            end
        end
        obs_q.delete(); exp_q.delete();
        send_frame(8'h3C, 0, 0, 6, -1);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        got = {byte_valid, byte_out, code_valid, is_break, is_extended, scancode, frame_err};
        exp = {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h05, 1'b0};
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL midframe_reset: got %s, expected %s", fmt(got), fmt(exp));
        end
        reset = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        exp_byte(KEY_D); send_frame(KEY_D, 0, 0, 11, -1);
        settle();
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL post_reset_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL post_reset_evt: got %s, expected %s", fmt(got), fmt(exp));
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [6];
        seq = '{KEY_A, PS2_BREAK, KEY_A, KEY_F, PS2_BREAK, KEY_S};
        for (int i = 0; i < 6; i++) begin
            exp_byte(seq[i]);
            send_frame(seq[i], 0, 0, 11, -1);
        end
        settle();
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL b2b_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL b2b_evt: got %s, expected %s", fmt(got), fmt(exp));
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_make();
        test_break();
        test_extended();
        test_parity_stop();
        test_timeout();
        test_glitch_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
